// File: rtl/dds_nco_pkg.sv
// -----------------------------------------------------------------------------
// dds_nco_pkg
// Shared types and constants for the multi-channel NCO:
//   quad_e       - phase quadrant (top two phase bits)
//   full_scale() - largest positive sample magnitude for a given width
//   LFSR_POLY / LFSR_SEED - dither LFSR taps (x^16+x^14+x^13+x^11+1) and seed
//   PIPE_STAGES  - register stages between issue and the AXI-stream output
// -----------------------------------------------------------------------------
package dds_nco_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam int PIPE_STAGES = 3;

  // Right-shifting Galois form: taps 16,14,13,11 map to mask 0xB400.
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Symmetric full scale: -2^(w-1) is never produced.
  function automatic int full_scale(input int out_dw);
    return (1 << (out_dw - 1)) - 1;
  endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// -----------------------------------------------------------------------------
// dds_quarter_lut
// Registered dual-read quarter-wave sine ROM. Entry k holds
// round(sin(pi/2 * k / 2^LUT_AW) * full_scale). The table is built by a
// $sin generate loop at elaboration. A full-scale flag per port overrides the
// ROM output, covering the 90-degree point the table cannot address.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   i_ce                    read enable (holds outputs when low)
//   i_sin_addr, i_cos_addr  quarter-wave addresses
//   i_sin_full, i_cos_full  force magnitude to full scale
//   o_sin_mag, o_cos_mag    registered unsigned magnitudes
// -----------------------------------------------------------------------------
module dds_quarter_lut
  import dds_nco_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_DW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_ce,
  input  logic [LUT_AW-1:0] i_sin_addr,
  input  logic [LUT_AW-1:0] i_cos_addr,
  input  logic              i_sin_full,
  input  logic              i_cos_full,
  output logic [OUT_DW-1:0] o_sin_mag,
  output logic [OUT_DW-1:0] o_cos_mag
);

  localparam int              DEPTH = 1 << LUT_AW;
  localparam logic [OUT_DW-1:0] FS  = OUT_DW'(full_scale(OUT_DW));

  function automatic logic [OUT_DW-1:0] lut_entry(input int k);
    real ang;
    ang = 3.14159265358979323846 / 2.0 * real'(k) / real'(DEPTH);
    return OUT_DW'($rtoi($sin(ang) * real'(FS) + 0.5));
  endfunction

  logic [OUT_DW-1:0] w_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign w_rom[k] = lut_entry(k);
  end

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // register samples the pre-edge values of its inputs, independent of
  // process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_sin_mag <= '0;
      o_cos_mag <= '0;
    end else if (i_ce) begin
      o_sin_mag <= i_sin_full ? FS : w_rom[i_sin_addr];
      o_cos_mag <= i_cos_full ? FS : w_rom[i_cos_addr];
    end
  end

endmodule

// File: rtl/dds_nco_multich.sv
// -----------------------------------------------------------------------------
// dds_nco_multich
// Time-multiplexed NCO: NUM_CH phase accumulators served round-robin, one
// sample per cycle, through a shared quarter-wave LUT. AXI-stream output with
// full backpressure; the whole pipeline stalls while tvalid && !tready.
// Pipeline: issue -> stage1 (phase regs, address compute) -> stage2 (LUT
// read) -> stage3 (sign, output regs). Issue at cycle t shows at t+3.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   en                           issue enable (bubbles when low)
//   sync                         clear all accumulators and the channel counter
//   cfg_valid/cfg_ch/cfg_ftw/cfg_poff   per-channel FTW / phase-offset write
//   m_axis_tdata {cos,sin}, m_axis_tuser (channel), m_axis_tlast (last ch),
//   m_axis_tvalid, m_axis_tready
// Build option: define DDS_NCO_DITHER_EN to add LFSR phase dither before
// truncation; undefined gives the deterministic datapath.
// -----------------------------------------------------------------------------
module dds_nco_multich
  import dds_nco_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int PHASE_DW = 32,
  parameter  int LUT_AW   = 10,
  parameter  int OUT_DW   = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                sync,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PHASE_DW-1:0] cfg_ftw,
  input  logic [PHASE_DW-1:0] cfg_poff,
  output logic [2*OUT_DW-1:0] m_axis_tdata,
  output logic [CH_W-1:0]     m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready
);

  localparam int              TRUNC_SH = PHASE_DW - LUT_AW - 2;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  logic [PHASE_DW-1:0]    r_acc  [NUM_CH];
  logic [PHASE_DW-1:0]    r_ftw  [NUM_CH];
  logic [PHASE_DW-1:0]    r_poff [NUM_CH];
  logic [CH_W-1:0]        r_cnt;
  logic [PIPE_STAGES-1:0] r_vld;
  logic [PIPE_STAGES-1:0] r_last;
  logic [CH_W-1:0]        r_ch   [PIPE_STAGES];
  quad_e                  r_s1_q, r_s2_q;
  logic [LUT_AW-1:0]      r_s1_idx;
  logic [OUT_DW-1:0]      r_sin, r_cos;

  logic                   w_adv;
  logic                   w_issue;
  logic [LUT_AW+1:0]      w_top;
  logic [LUT_AW-1:0]      w_sin_addr, w_cos_addr;
  logic                   w_sin_full, w_cos_full;
  logic [OUT_DW-1:0]      w_sin_mag, w_cos_mag;

  // A stalled output freezes everything behind it.
  assign w_adv   = !(r_vld[PIPE_STAGES-1] && !m_axis_tready);
  assign w_issue = w_adv && en;

`ifdef DDS_NCO_DITHER_EN
  localparam int          DITHER_RAW  = TRUNC_SH;
  localparam int          DITHER_W    = (DITHER_RAW > 16) ? 16 : DITHER_RAW;
  localparam logic [15:0] DITHER_MASK = 16'((32'd1 << DITHER_W) - 32'd1);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_lfsr <= LFSR_SEED;
    else if (w_issue) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
  end

  assign w_top = (LUT_AW+2)'((r_acc[r_cnt] + r_poff[r_cnt]
                 + PHASE_DW'(r_lfsr & DITHER_MASK)) >> TRUNC_SH);
`else
  // Truncation only: keep the top LUT_AW+2 phase bits.
  assign w_top = (LUT_AW+2)'((r_acc[r_cnt] + r_poff[r_cnt]) >> TRUNC_SH);
`endif

  // NOTE: the small per-channel register arrays are reset explicitly so a
  // freshly reset NCO has a defined phase; only true RAM/ROM stays unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
      r_cnt <= '0;
    end else if (w_adv) begin
      if (sync) begin
        // Clear wins over this cycle's accumulate; the issued sample already
        // used the pre-clear phase.
        for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
        r_cnt <= '0;
      end else if (en) begin
        r_acc[r_cnt] <= r_acc[r_cnt] + r_ftw[r_cnt];
        r_cnt        <= (r_cnt == LAST_CH) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // Config is independent of the stall; a same-cycle issue sees old values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ftw[i]  <= '0;
        r_poff[i] <= '0;
      end
    end else if (cfg_valid) begin
      r_ftw[cfg_ch]  <= cfg_ftw;
      r_poff[cfg_ch] <= cfg_poff;
    end
  end

  // Odd quadrants read the table backwards; idx = 0 there is the 90-degree
  // point, one past the last entry, so it is forced to full scale instead.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_sin_addr = r_s1_idx;
    w_cos_addr = -r_s1_idx;
    w_sin_full = 1'b0;
    w_cos_full = (r_s1_idx == '0);
    if (r_s1_q[0]) begin
      w_sin_addr = -r_s1_idx;
      w_cos_addr = r_s1_idx;
      w_sin_full = (r_s1_idx == '0);
      w_cos_full = 1'b0;
    end
  end

  dds_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_DW (OUT_DW)
  ) u_lut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_ce       (w_adv),
    .i_sin_addr (w_sin_addr),
    .i_cos_addr (w_cos_addr),
    .i_sin_full (w_sin_full),
    .i_cos_full (w_cos_full),
    .o_sin_mag  (w_sin_mag),
    .o_cos_mag  (w_cos_mag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld    <= '0;
      r_last   <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) r_ch[i] <= '0;
      r_s1_q   <= Q0;
      r_s1_idx <= '0;
      r_s2_q   <= Q0;
      r_sin    <= '0;
      r_cos    <= '0;
    end else if (w_adv) begin
      r_vld    <= {r_vld[PIPE_STAGES-2:0], en};
      r_last   <= {r_last[PIPE_STAGES-2:0], r_cnt == LAST_CH};
      r_ch[0]  <= r_cnt;
      for (int i = 1; i < PIPE_STAGES; i++) r_ch[i] <= r_ch[i-1];
      r_s1_q   <= quad_e'(w_top[LUT_AW+1:LUT_AW]);
      r_s1_idx <= w_top[LUT_AW-1:0];
      r_s2_q   <= r_s1_q;
      // Magnitude never exceeds full scale, so negation cannot overflow.
      r_sin    <= (r_s2_q == Q2 || r_s2_q == Q3) ? -w_sin_mag : w_sin_mag;
      r_cos    <= (r_s2_q == Q1 || r_s2_q == Q2) ? -w_cos_mag : w_cos_mag;
    end
  end

  assign m_axis_tdata  = {r_cos, r_sin};
  assign m_axis_tuser  = r_ch[PIPE_STAGES-1];
  assign m_axis_tlast  = r_last[PIPE_STAGES-1];
  assign m_axis_tvalid = r_vld[PIPE_STAGES-1];

endmodule

// File: tb/tb_dds_nco_multich.sv
// -----------------------------------------------------------------------------
// tb_dds_nco_multich
// Scoreboard bench for dds_nco_multich (NUM_CH=4, PHASE_DW=32, LUT_AW=10,
// OUT_DW=16). A reference model tracks accumulators and pipeline occupancy
// and pushes the expected sample on every issue; a monitor compares the
// queue head whenever tvalid is high and pops on handshake. Magnitudes come
// from a hand-computed table of the few LUT entries the stimulus reaches.
// -----------------------------------------------------------------------------
module tb_dds_nco_multich;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, sync, cfg_valid;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_ftw, cfg_poff;
  logic [31:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

  always #5 clk = ~clk;

  dds_nco_multich dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en),
    .sync          (sync),
    .cfg_valid     (cfg_valid),
    .cfg_ch        (cfg_ch),
    .cfg_ftw       (cfg_ftw),
    .cfg_poff      (cfg_poff),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [31:0] tdata;
    logic [1:0]  tuser;
    logic        tlast;
  } samp_t;

  samp_t exp_q[$];

  // Hand-computed LUT entries (32767 * sin(pi/2 * k/1024), rounded).
  function automatic int hand_mag(input int a);
    case (a)
      0:       return 0;
      1:       return 50;
      512:     return 23170;
      1023:    return 32767;
      default: return 99999;
    endcase
  endfunction

  function automatic samp_t exp_sample(input logic [31:0] p, input logic [1:0] ch);
    samp_t s;
    int q, idx, sa, ca, sm, cm, sv, cv;
    q   = int'(p[31:30]);
    idx = int'(p[29:20]);
    sa  = (q % 2 == 1) ? (1024 - idx) % 1024 : idx;
    ca  = (q % 2 == 1) ? idx : (1024 - idx) % 1024;
    sm  = (q % 2 == 1 && idx == 0) ? 32767 : hand_mag(sa);
    cm  = (q % 2 == 0 && idx == 0) ? 32767 : hand_mag(ca);
    sv  = (q >= 2) ? -sm : sm;
    cv  = (q == 1 || q == 2) ? -cm : cm;
    s.tdata = {16'(cv), 16'(sv)};
    s.tuser = ch;
    s.tlast = (ch == 2'd3);
    return s;
  endfunction

  // Reference model.
  logic [31:0] m_acc [4];
  logic [31:0] m_ftw [4];
  logic [31:0] m_poff[4];
  logic [1:0]  m_cnt;
  logic [2:0]  mv;
  logic        m_adv;

  assign m_adv = !(mv[2] && !m_axis_tready);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        m_acc[i]  <= '0;
        m_ftw[i]  <= '0;
        m_poff[i] <= '0;
      end
      m_cnt <= '0;
      mv    <= '0;
      exp_q.delete();
    end else begin
      if (m_adv) begin
        if (en) exp_q.push_back(exp_sample(m_acc[m_cnt] + m_poff[m_cnt], m_cnt));
        mv <= {mv[1:0], en};
        if (sync) begin
          for (int i = 0; i < 4; i++) m_acc[i] <= '0;
          m_cnt <= '0;
        end else if (en) begin
          m_acc[m_cnt] <= m_acc[m_cnt] + m_ftw[m_cnt];
          m_cnt        <= m_cnt + 2'd1;
        end
      end
      if (cfg_valid) begin
        m_ftw[cfg_ch]  <= cfg_ftw;
        m_poff[cfg_ch] <= cfg_poff;
      end
    end
  end

  // Monitor: compares on every valid cycle (stalled ones too), pops on handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      check("tvalid", 64'(m_axis_tvalid), 64'(mv[2]));
      if (m_axis_tvalid) begin
        check("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("tdata", 64'(m_axis_tdata), 64'(exp_q[0].tdata));
          check("tuser", 64'(m_axis_tuser), 64'(exp_q[0].tuser));
          check("tlast", 64'(m_axis_tlast), 64'(exp_q[0].tlast));
          if (m_axis_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [31:0] ftw, input logic [31:0] poff);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_ftw   = ftw;
    cfg_poff  = poff;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Stop issuing, reprogram all channels, clear, restart.
  task automatic program_all(input logic [31:0] ftw, input logic [31:0] poff_step);
    en = 1'b0;
    for (int c = 0; c < 4; c++) cfg(2'(c), ftw, 32'(c) * poff_step);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    en   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    reset_n = 1'b0; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_ftw = '0; cfg_poff = '0; m_axis_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata",  64'(m_axis_tdata),  64'(0));
    check("rst_tuser",  64'(m_axis_tuser),  64'(0));
    check("rst_tlast",  64'(m_axis_tlast),  64'(0));
    reset_n = 1'b1;
    tick();

    // Quarter step on channel 0: sin 0,32767,0,-32767 / cos 32767,0,-32767,0.
    cfg(2'd0, 32'h4000_0000, 32'h0);
    en  = 1'b1;
    lat = 0;
    while (!m_axis_tvalid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(3));
    repeat (20) tick();

    // Static phase offsets c * 90 degrees.
    program_all(32'h0, 32'h4000_0000);
    repeat (16) tick();

    // Backpressure: 5-cycle stall, then a sparse ready pattern.
    m_axis_tready = 1'b0;
    repeat (5) tick();
    m_axis_tready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 12; i++) begin
      m_axis_tready = (i % 3 != 0);
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (4) tick();

    // Config write colliding with the channel-2 issue.
    lat = 0;
    while (m_cnt != 2'd2 && lat < 8) begin
      tick();
      lat++;
    end
    cfg(2'd2, 32'h2000_0000, 32'h8000_0000);
    repeat (12) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    repeat (12) tick();

    // Wrap: FTW = -1 for at least 16 samples per channel.
    program_all(32'hFFFF_FFFF, 32'h0);
    repeat (70) tick();

    // Asynchronous reset mid-cycle, mid-stream.
    #2 reset_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("arst_tuser",  64'(m_axis_tuser),  64'(0));
    check("arst_tdata",  64'(m_axis_tdata),  64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) tick();

    en = 1'b0;
    repeat (6) tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
